byte_sram_responder: RTL

- Target end of the 8-bit word-port protocol (word_rd / word_wr / word_addr / word_data / word_q / word_busy) driven by the bridge-side byte initiators.
- Serves each single-byte request against a 16-bit asynchronous SRAM/PSRAM using byte-lane selects and fixed, parameterised wait states.
- Sits between the bridge byte initiator and the cart SRAM pins, in the clk_sys domain.

---
 rtl/neo_mem_pkg.sv | 10 +
 rtl/byte_lane_mux.sv | 15 +
 rtl/byte_sram_responder.sv | 111 +++++++++++
 3 files changed

// File: rtl/neo_mem_pkg.sv
// neo_mem_pkg: state encoding, lane selection and default wait states shared by the SRAM responders
package neo_mem_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_TURN} mem_state_t;
    localparam int DEF_RD_WAIT = 3;
    localparam int DEF_WR_WAIT = 3;
    localparam int DEF_TURN = 1;
    function automatic logic lane_select(input logic addr0, input logic swap);
        return addr0 ^ swap;
    endfunction
endpackage

// File: rtl/byte_lane_mux.sv
// byte_lane_mux: byte extract from a 16-bit read word, byte replicate and active-low lane strobes for writes
module byte_lane_mux (
    input  logic        lane,
    input  logic [15:0] rd_word,
    input  logic [7:0]  wr_byte,
    output logic [7:0]  rd_byte,
    output logic [15:0] wr_word,
    output logic        ub_n,
    output logic        lb_n
);
    assign rd_byte = lane ? rd_word[15:8] : rd_word[7:0];
    assign wr_word = {wr_byte, wr_byte};
    assign ub_n = ~lane;
    assign lb_n = lane;
endmodule

// File: rtl/byte_sram_responder.sv
// byte_sram_responder: serves single-byte word-port reads/writes against a 16-bit async SRAM with fixed wait states
module byte_sram_responder
    import neo_mem_pkg::*;
#(
    parameter int SRAM_AW = 21,
    parameter int RD_WAIT = DEF_RD_WAIT,
    parameter int WR_WAIT = DEF_WR_WAIT,
    parameter int TURN = DEF_TURN
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               byte_swap,
    input  logic               word_rd,
    input  logic               word_wr,
    input  logic [25:0]        word_addr,
    input  logic [7:0]         word_data,
    output logic [7:0]         word_q,
    output logic               word_busy,
    output logic               protocol_err,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);
    mem_state_t state;
    logic [7:0] cnt;
    logic lane_r, lane, ub_n, lb_n, strobe, unused_addr;
    logic [7:0] rd_byte;
    logic [15:0] wr_word;

    assign strobe = word_rd | word_wr;
    assign word_busy = reset | (state != ST_IDLE) | strobe;
    // in IDLE the lane comes straight from the request so the strobes can be registered on the accept edge
    assign lane = (state == ST_IDLE) ? lane_select(word_addr[0], byte_swap) : lane_r;
    assign unused_addr = ^word_addr[25:SRAM_AW+1];

    byte_lane_mux u_lane_mux (
        .lane    (lane),
        .rd_word (sram_dq_i),
        .wr_byte (word_data),
        .rd_byte (rd_byte),
        .wr_word (wr_word),
        .ub_n    (ub_n),
        .lb_n    (lb_n)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt <= '0;
            lane_r <= 1'b0;
            word_q <= '0;
            protocol_err <= 1'b0;
            sram_a <= '0;
            sram_dq_o <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
        end else begin
            if (state != ST_IDLE && strobe) protocol_err <= 1'b1;
            case (state)
                ST_IDLE: if (strobe) begin
                    sram_a <= word_addr[SRAM_AW:1];
                    lane_r <= lane;
                    sram_ce_n <= 1'b0;
                    sram_ub_n <= ub_n;
                    sram_lb_n <= lb_n;
                    if (word_rd) begin
                        sram_oe_n <= 1'b0;
                        cnt <= 8'(RD_WAIT);
                        state <= ST_READ;
                        if (word_wr) protocol_err <= 1'b1;
                    end else begin
                        sram_we_n <= 1'b0;
                        sram_dq_o <= wr_word;
                        sram_dq_oe <= 1'b1;
                        cnt <= 8'(WR_WAIT);
                        state <= ST_WRITE;
                    end
                end
                ST_READ, ST_WRITE: if (cnt == 8'd1) begin
                    if (state == ST_READ) word_q <= rd_byte;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    cnt <= 8'(TURN);
                    state <= (TURN == 0) ? ST_IDLE : ST_TURN;
                    if (TURN == 0) sram_dq_oe <= 1'b0;
                end else begin
                    cnt <= cnt - 8'd1;
                end
                ST_TURN: if (cnt == 8'd1) begin
                    state <= ST_IDLE;
                    sram_dq_oe <= 1'b0;
                end else begin
                    cnt <= cnt - 8'd1;
                end
            endcase
        end
    end
endmodule
